// File: rtl/cache_req_frontend.sv
// Single-outstanding request front-end for a 4-way cache set: it splits and checks the address,
// issues one op strobe, then waits for hit data, a miss flag or a timeout, and returns one response.
module cache_req_frontend #(
  parameter int ADDR_W  = 36,
  parameter int TAG_W   = 24,
  parameter int INDEX_W = 6,
  parameter int OFF_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic [63:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [63:0]        resp_rdata,
  output logic [1:0]         resp_status,
  output logic               set_enable,
  output logic [INDEX_W-1:0] set_index,
  output logic [2:0]         set_write_enable,
  output logic [OFF_W-1:0]   set_block_offset,
  output logic [1:0]         set_data_size,
  output logic [TAG_W-1:0]   set_tag,
  output logic [63:0]        set_write_data,
  output logic [31:0]        set_n_ops,
  input  logic [127:0]       set_out_data,
  input  logic [1:0]         set_write_miss,
  input  logic [1:0]         set_read_miss,
  input  logic [1:0]         set_data_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] ST_HIT      = 2'd0;
  localparam logic [1:0] ST_MISS     = 2'd1;
  localparam logic [1:0] ST_MISALIGN = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;
  localparam logic [7:0] TMO         = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        wr_q;
  logic        accept, misalign, rd_miss, wr_miss, dat_rdy, tmo_hit;

  // Offset bits that must be zero for an access of 1<<size bytes.
  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] size);
    logic [OFF_W-1:0] m;
    m = '0;
    case (size)
      2'd1:    m[0]   = 1'b1;
      2'd2:    m[1:0] = 2'b11;
      2'd3:    m[2:0] = 3'b111;
      default: m      = '0;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_mask(input logic [127:0] data, input logic [1:0] size);
    case (size)
      2'd0:    return {56'd0, data[7:0]};
      2'd1:    return {48'd0, data[15:0]};
      2'd2:    return {32'd0, data[31:0]};
      default: return data[63:0];
    endcase
  endfunction

  assign accept   = req_valid && (state == S_IDLE);
  assign misalign = |(req_addr[OFF_W-1:0] & align_mask(req_size));
  assign rd_miss  = |set_read_miss;
  assign wr_miss  = |set_write_miss;
  assign dat_rdy  = |set_data_ready;
  assign tmo_hit  = (wait_cnt + 8'd1) == TMO;

  assign req_ready        = (state == S_IDLE);
  assign resp_valid       = (state == S_RESP);
  assign set_enable       = (state == S_ISSUE);
  assign set_write_enable = (state == S_ISSUE) ? {2'b00, wr_q} : 3'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = misalign ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wr_q || rd_miss || dat_rdy || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Captured request fields drive the set directly, so they stay stable through ISSUE and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q             <= 1'b0;
      wait_cnt         <= '0;
      set_index        <= '0;
      set_block_offset <= '0;
      set_data_size    <= '0;
      set_tag          <= '0;
      set_write_data   <= '0;
      set_n_ops        <= '0;
      resp_rdata       <= '0;
      resp_status      <= ST_HIT;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          wr_q             <= req_write;
          set_tag          <= req_addr[ADDR_W-1:OFF_W+INDEX_W];
          set_index        <= req_addr[OFF_W+INDEX_W-1:OFF_W];
          set_block_offset <= req_addr[OFF_W-1:0];
          set_data_size    <= req_size;
          set_write_data   <= req_wdata;
          if (misalign) begin
            resp_status <= ST_MISALIGN;
            resp_rdata  <= '0;
          end else begin
            set_n_ops <= set_n_ops + 32'd1;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (wr_q) begin
            resp_status <= wr_miss ? ST_MISS : ST_HIT;
            resp_rdata  <= '0;
          end else if (rd_miss) begin
            resp_status <= ST_MISS;
            resp_rdata  <= '0;
          end else if (dat_rdy) begin
            resp_status <= ST_HIT;
            resp_rdata  <= load_mask(set_out_data, set_data_size);
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (tmo_hit) begin
              resp_status <= ST_TIMEOUT;
              resp_rdata  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_frontend.sv
// Directed bench for cache_req_frontend: stimulus pushes expected responses into a queue and a
// separate negedge monitor pops and compares each response handshake.
module tb_cache_req_frontend;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [35:0]  req_addr;
  logic [1:0]   req_size;
  logic [63:0]  req_wdata;
  logic         resp_valid, resp_ready;
  logic [63:0]  resp_rdata;
  logic [1:0]   resp_status;
  logic         set_enable;
  logic [5:0]   set_index;
  logic [2:0]   set_write_enable;
  logic [5:0]   set_block_offset;
  logic [1:0]   set_data_size;
  logic [23:0]  set_tag;
  logic [63:0]  set_write_data;
  logic [31:0]  set_n_ops;
  logic [127:0] set_out_data;
  logic [1:0]   set_write_miss, set_read_miss, set_data_ready;

  cache_req_frontend dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_status(resp_status),
    .set_enable(set_enable), .set_index(set_index), .set_write_enable(set_write_enable),
    .set_block_offset(set_block_offset), .set_data_size(set_data_size), .set_tag(set_tag),
    .set_write_data(set_write_data), .set_n_ops(set_n_ops), .set_out_data(set_out_data),
    .set_write_miss(set_write_miss), .set_read_miss(set_read_miss),
    .set_data_ready(set_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] rd;
    bit          chk_rd;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model_nops = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected response", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_status", resp_status, e.st);
        if (e.chk_rd) check("resp_rdata", resp_rdata, e.rd);
      end
    end
  end

  task automatic send(input logic [35:0] addr, input logic wr, input logic [1:0] size,
                      input logic [63:0] wdata);
    int n = 0;
    req_addr = addr; req_write = wr; req_size = size; req_wdata = wdata; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready before accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full aligned transaction: flags are presented in WAIT cycle cyc; returns via checks only.
  task automatic run(input logic [35:0] addr, input logic wr, input logic [1:0] size,
                     input logic [63:0] wdata, input int cyc, input bit wmiss, input bit rmiss,
                     input bit dr, input logic [127:0] odata, input logic [1:0] exp_st,
                     input logic [63:0] exp_rd, input int exp_lat);
    exp_t e;
    int   lat = -1;
    e.st = exp_st; e.rd = exp_rd; e.chk_rd = !wr;
    sb.push_back(e);
    model_nops++;
    send(addr, wr, size, wdata);
    @(negedge clk);
    check("issue set_enable", set_enable, 1);
    check("issue set_write_enable", set_write_enable, wr ? 3'd1 : 3'd0);
    check("issue set_tag", set_tag, addr[35:12]);
    check("issue set_index", set_index, addr[11:6]);
    check("issue set_block_offset", set_block_offset, addr[5:0]);
    check("issue set_data_size", set_data_size, size);
    check("issue set_write_data", set_write_data, wdata);
    check("issue set_n_ops", set_n_ops, model_nops);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      set_write_miss = (k == cyc && wmiss) ? 2'b01 : 2'b00;
      set_read_miss  = (k == cyc && rmiss) ? 2'b10 : 2'b00;
      set_data_ready = (k == cyc && dr)    ? 2'b01 : 2'b00;
      set_out_data   = (k == cyc) ? odata : 128'd0;
      @(negedge clk);
      if (k == 1) begin
        check("wait set_enable", set_enable, 0);
        check("wait set_write_enable", set_write_enable, 3'd2);
        check("wait set_tag held", set_tag, addr[35:12]);
      end
      if (resp_valid) begin lat = k; break; end
    end
    check("response latency", lat, exp_lat);
    @(posedge clk); #1;
    set_write_miss = 0; set_read_miss = 0; set_data_ready = 0; set_out_data = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = 0; req_write = 0; req_size = 0; req_wdata = 0;
    resp_ready = 1'b1; set_out_data = 0; set_write_miss = 0; set_read_miss = 0; set_data_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", req_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset set_enable", set_enable, 0);
    check("reset set_write_enable", set_write_enable, 3'd2);
    check("reset set_n_ops", set_n_ops, 0);
    check("reset resp_status", resp_status, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store hit: tag 0xF, index 3, offset 8
    run(36'h0000F0C8, 1, 2'd2, 64'hDEADBEEF, 1, 0, 0, 0, 0, 2'd0, 0, 2);
    check("store1 n_ops", set_n_ops, 32'd1);
    check("store1 tag", set_tag, 24'h00000F);
    check("store1 index", set_index, 6'd3);
    check("store1 offset", set_block_offset, 6'd8);
    // Store miss
    run(36'h000000040, 1, 2'd3, 64'h1122334455667788, 1, 1, 0, 0, 0, 2'd1, 0, 2);
    // Load 16b, data in WAIT cycle 3
    run(36'h0000100C0, 0, 2'd1, 0, 3, 0, 0, 1, 128'h1234ABCD, 2'd0, 64'hABCD, 4);
    // Load 8b and 64b masking
    run(36'h000000101, 0, 2'd0, 0, 2, 0, 0, 1,
        128'hFFFF_FFFF_FFFF_FFFF_0123_4567_89AB_CDEF, 2'd0, 64'hEF, 3);
    run(36'h000000108, 0, 2'd3, 0, 1, 0, 0, 1,
        128'hFFFF_FFFF_FFFF_FFFF_0123_4567_89AB_CDEF, 2'd0, 64'h0123_4567_89AB_CDEF, 2);

    // Misaligned 64b load: no strobe, n_ops unchanged
    begin
      exp_t e;
      int   lat = -1;
      bit   seen_en = 0;
      e.st = 2'd2; e.rd = 0; e.chk_rd = 1;
      sb.push_back(e);
      send(36'h000000004, 0, 2'd3, 0);
      for (int k = 0; k <= 3; k++) begin
        if (k > 0) @(posedge clk);
        @(negedge clk);
        if (set_enable) seen_en = 1;
        if (resp_valid && lat < 0) lat = k;
        if (resp_valid) break;
      end
      check("misalign latency<=1", lat >= 0 && lat <= 1, 1);
      check("misalign no set_enable", seen_en, 0);
      check("misalign n_ops", set_n_ops, model_nops);
      @(posedge clk); #1;
    end

    // Miss and data_ready together: miss wins
    run(36'h000000200, 0, 2'd2, 0, 1, 0, 1, 1, 128'hCAFEF00D, 2'd1, 0, 2);
    // No flags: timeout on the 15th WAIT cycle
    run(36'h000000300, 0, 2'd2, 0, 99, 0, 0, 0, 0, 2'd3, 0, 16);

    // Response held with a new request pending
    resp_ready = 1'b0;
    run(36'h000000400, 1, 2'd0, 64'h5A, 1, 1, 0, 0, 0, 2'd1, 0, 2);
    req_addr = 36'h000000500; req_write = 0; req_size = 2'd0; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold resp_valid", resp_valid, 1);
      check("hold resp_status", resp_status, 2'd1);
      check("hold req_ready", req_ready, 0);
      check("hold set_enable", set_enable, 0);
      check("hold n_ops", set_n_ops, model_nops);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("post-handshake req_ready", req_ready, 1);

    // Asynchronous reset in the middle of WAIT
    send(36'h000000600, 0, 2'd2, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midop reset req_ready", req_ready, 1);
    check("midop reset resp_valid", resp_valid, 0);
    check("midop reset set_enable", set_enable, 0);
    check("midop reset set_write_enable", set_write_enable, 3'd2);
    check("midop reset set_n_ops", set_n_ops, 0);
    check("midop reset set_tag", set_tag, 0);
    check("midop reset resp_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_nops = 0;
    @(posedge clk); #1;
    run(36'h0000F0C8, 1, 2'd2, 64'hDEADBEEF, 1, 0, 0, 0, 0, 2'd0, 0, 2);
    check("after reset n_ops", set_n_ops, 32'd1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
